// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter between the WB stage and a multi-cycle unit, with an MC scoreboard.
// Latency: zero; the grant, write port and hazard outputs are combinational from inputs and registered state.
// Backpressure: WB normally wins. MC is forced after STARVE_LIMIT lost cycles, and then WB sees wb_stall_o.
// Optional: define REGARB_PERF_EN to add the saturating conflict_cnt_o / force_cnt_o counters.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_stall_o,
  input  logic        mc_issue_i,
  input  logic [4:0]  mc_issue_rd_i,
  input  logic        mc_valid_i,
  input  logic [4:0]  mc_rd_i,
  input  logic [31:0] mc_data_i,
  output logic        mc_ready_o,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic        hazard_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] RDdata_o,
  output logic        RegWrite_o,
  output logic [31:0] pending_o
`ifdef REGARB_PERF_EN
  ,
  output logic [15:0] conflict_cnt_o,
  output logic [15:0] force_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pending_q, pending_d;
  logic        mc_grant, wb_grant, force_grant, haz;

  // Arbitration, write-port mux and hazard detection; everything is held at 0 during reset.
  always_comb begin
    force_grant = 1'b0;
    mc_grant    = 1'b0;
    wb_grant    = 1'b0;
    haz         = 1'b0;
    wb_stall_o  = 1'b0;
    mc_ready_o  = 1'b0;
    hazard_o    = 1'b0;
    RegWrite_o  = 1'b0;
    RDaddr_o    = 5'd0;
    RDdata_o    = 32'd0;
    pending_o   = 32'd0;
    if (!rst_i) begin
      force_grant = (state_q == FORCE) && mc_valid_i;
      mc_grant    = force_grant || ((state_q != FORCE) && mc_valid_i && !wb_valid_i);
      wb_grant    = wb_valid_i && !force_grant;
      // Hazards look at registered pending only, so a same-cycle clear still stalls.
      haz = ((rs1_addr_i != 5'd0) && pending_q[rs1_addr_i]) ||
            ((rs2_addr_i != 5'd0) && pending_q[rs2_addr_i]) ||
            (mc_issue_i && pending_q[mc_issue_rd_i]);
      wb_stall_o = force_grant && wb_valid_i;
      mc_ready_o = mc_grant;
      hazard_o   = haz;
      pending_o  = pending_q;
      if (mc_grant) begin
        RegWrite_o = 1'b1;
        RDaddr_o   = mc_rd_i;
        RDdata_o   = mc_data_i;
      end else if (wb_grant) begin
        RegWrite_o = 1'b1;
        RDaddr_o   = wb_rd_i;
        RDdata_o   = wb_data_i;
      end
    end
  end

  // Starvation FSM and scoreboard next state; an issue's set wins over a same-cycle grant's clear.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    unique case (state_q)
      IDLE: begin
        if (mc_valid_i && !mc_grant) begin
          cnt_d   = 4'd1;
          state_d = (LIMIT == 4'd1) ? FORCE : WAIT;
        end
      end
      WAIT: begin
        if (!mc_valid_i || mc_grant) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == LIMIT) state_d = FORCE;
        end
      end
      FORCE: begin
        if (mc_grant || !mc_valid_i) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
    if (mc_grant) pending_d[mc_rd_i] = 1'b0;
    if (mc_issue_i && !haz && (mc_issue_rd_i != 5'd0)) pending_d[mc_issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      pending_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

`ifdef REGARB_PERF_EN
  logic [15:0] conflict_q, force_q;

  // Saturating counters: WB/MC collision cycles and forced MC grants.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_q <= 16'd0;
      force_q    <= 16'd0;
    end else begin
      if (wb_valid_i && mc_valid_i && (conflict_q != 16'hFFFF)) conflict_q <= conflict_q + 16'd1;
      if (force_grant && (force_q != 16'hFFFF)) force_q <= force_q + 16'd1;
    end
  end

  assign conflict_cnt_o = conflict_q;
  assign force_cnt_o    = force_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset gating, WB/MC grants, starvation forcing, scoreboard hazards.
// Inputs change 1 ns after posedge; combinational outputs are sampled 2 ns later.
// Expected values are hand-computed constants.
module tb_regfile_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        wb_stall_o;
  logic        mc_issue_i;
  logic [4:0]  mc_issue_rd_i;
  logic        mc_valid_i;
  logic [4:0]  mc_rd_i;
  logic [31:0] mc_data_i;
  logic        mc_ready_o;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        hazard_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic        RegWrite_o;
  logic [31:0] pending_o;
`ifdef REGARB_PERF_EN
  logic [15:0] conflict_cnt_o;
  logic [15:0] force_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .wb_stall_o(wb_stall_o),
    .mc_issue_i(mc_issue_i), .mc_issue_rd_i(mc_issue_rd_i),
    .mc_valid_i(mc_valid_i), .mc_rd_i(mc_rd_i), .mc_data_i(mc_data_i), .mc_ready_o(mc_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .hazard_o(hazard_o),
    .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o), .RegWrite_o(RegWrite_o), .pending_o(pending_o)
`ifdef REGARB_PERF_EN
    , .conflict_cnt_o(conflict_cnt_o), .force_cnt_o(force_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 1 ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    wb_valid_i = 0; wb_rd_i = 0; wb_data_i = 0;
    mc_issue_i = 0; mc_issue_rd_i = 0;
    mc_valid_i = 0; mc_rd_i = 0; mc_data_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0;
  endtask

  // WB and MC both valid: WB wins 4 cycles, MC is forced on the 5th, then WB alone.
  task automatic starve_run(input string tag, input logic [4:0] mrd);
    mc_valid_i = 1; mc_rd_i = mrd; mc_data_i = 32'hCAFE_0000 | 32'(mrd);
    wb_valid_i = 1;
    for (int i = 1; i <= 4; i++) begin
      wb_rd_i = 5'(i + 10); wb_data_i = 32'h100 + 32'(i);
      settle();
      check({tag, "_wb_addr"}, 32'(RDaddr_o), 32'(i + 10));
      check({tag, "_wb_ready"}, 32'(mc_ready_o), 32'd0);
      check({tag, "_wb_stall"}, 32'(wb_stall_o), 32'd0);
      step();
    end
    wb_rd_i = 5'd20; wb_data_i = 32'h200;
    settle();
    check({tag, "_force_ready"}, 32'(mc_ready_o), 32'd1);
    check({tag, "_force_stall"}, 32'(wb_stall_o), 32'd1);
    check({tag, "_force_addr"}, 32'(RDaddr_o), 32'(mrd));
    check({tag, "_force_data"}, RDdata_o, 32'hCAFE_0000 | 32'(mrd));
    check({tag, "_force_we"}, 32'(RegWrite_o), 32'd1);
    step();
    mc_valid_i = 0;
    settle();
    check({tag, "_after_addr"}, 32'(RDaddr_o), 32'd20);
    check({tag, "_after_stall"}, 32'(wb_stall_o), 32'd0);
    check({tag, "_after_ready"}, 32'(mc_ready_o), 32'd0);
    step();
    wb_valid_i = 0;
  endtask

  initial begin
    idle_inputs();
    rst_i = 1;
    step();
    step();
    // Reset gating: a WB request during reset must not reach the write port.
    wb_valid_i = 1; wb_rd_i = 5; wb_data_i = 32'h1234; mc_valid_i = 1; mc_rd_i = 3;
    settle();
    check("rst_we", 32'(RegWrite_o), 32'd0);
    check("rst_addr", 32'(RDaddr_o), 32'd0);
    check("rst_ready", 32'(mc_ready_o), 32'd0);
    check("rst_pending", pending_o, 32'd0);
    mc_valid_i = 0; mc_rd_i = 0;
    step();

    // 1. WB only.
    rst_i = 0;
    settle();
    check("wb_we", 32'(RegWrite_o), 32'd1);
    check("wb_addr", 32'(RDaddr_o), 32'd5);
    check("wb_data", RDdata_o, 32'h1234);
    check("wb_stall", 32'(wb_stall_o), 32'd0);
    check("wb_ready", 32'(mc_ready_o), 32'd0);
    step();

    // 2. MC issue rd=7, RAW on rs1, then MC return with WB idle.
    idle_inputs();
    mc_issue_i = 1; mc_issue_rd_i = 7;
    settle();
    check("iss7_hazard", 32'(hazard_o), 32'd0);
    check("iss7_we", 32'(RegWrite_o), 32'd0);
    step();
    mc_issue_i = 0; rs1_addr_i = 7;
    settle();
    check("p7_pending", pending_o, 32'h80);
    check("p7_hazard", 32'(hazard_o), 32'd1);
    step();
    mc_valid_i = 1; mc_rd_i = 7; mc_data_i = 32'hAA;
    settle();
    check("mc7_ready", 32'(mc_ready_o), 32'd1);
    check("mc7_addr", 32'(RDaddr_o), 32'd7);
    check("mc7_data", RDdata_o, 32'hAA);
    check("mc7_hazard_same_cycle", 32'(hazard_o), 32'd1);
    step();
    mc_valid_i = 0;
    settle();
    check("clr7_pending", pending_o, 32'd0);
    check("clr7_hazard", 32'(hazard_o), 32'd0);
    rs1_addr_i = 0;
    step();

    // 3. Starvation forcing with STARVE_LIMIT=4, MC result for rd=9 issued beforehand.
    mc_issue_i = 1; mc_issue_rd_i = 9;
    step();
    mc_issue_i = 0;
    starve_run("starve", 5'd9);
    settle();
    check("starve_pending", pending_o, 32'd0);
`ifdef REGARB_PERF_EN
    check("perf_conflict", 32'(conflict_cnt_o), 32'd5);
    check("perf_force", 32'(force_cnt_o), 32'd1);
`endif

    // 4. WAW on issue, issue to x0, RAW via rs2, set-wins on a same-cycle clear.
    mc_issue_i = 1; mc_issue_rd_i = 3;
    step();
    settle();
    check("waw_hazard", 32'(hazard_o), 32'd1);
    step();
    check("waw_pending", pending_o, 32'h8);
    mc_issue_rd_i = 0;
    settle();
    check("x0_hazard", 32'(hazard_o), 32'd0);
    step();
    mc_issue_i = 0;
    settle();
    check("x0_pending", pending_o, 32'h8);
    rs2_addr_i = 3;
    settle();
    check("rs2_hazard", 32'(hazard_o), 32'd1);
    rs2_addr_i = 0;
    // Grant to unpending rd=5 while issuing rd=5: write proceeds and the set wins.
    mc_valid_i = 1; mc_rd_i = 5; mc_data_i = 32'h55; mc_issue_i = 1; mc_issue_rd_i = 5;
    settle();
    check("perr_ready", 32'(mc_ready_o), 32'd1);
    check("perr_addr", 32'(RDaddr_o), 32'd5);
    step();
    idle_inputs();
    settle();
    check("setwins_pending", pending_o, 32'h28);
    // Drain rd=3 and rd=5.
    mc_valid_i = 1; mc_rd_i = 3;
    step();
    mc_rd_i = 5;
    step();
    mc_valid_i = 0;
    settle();
    check("drain_pending", pending_o, 32'd0);

    // 5. Reset in WAIT with pending 0x410.
    mc_issue_i = 1; mc_issue_rd_i = 4;
    step();
    mc_issue_rd_i = 10;
    step();
    mc_issue_i = 0;
    wb_valid_i = 1; wb_rd_i = 1; wb_data_i = 32'h11; mc_valid_i = 1; mc_rd_i = 4; mc_data_i = 32'h44;
    settle();
    check("wait_pending", pending_o, 32'h410);
    check("wait_wb_addr", 32'(RDaddr_o), 32'd1);
    step();
    rst_i = 1; rs1_addr_i = 4; mc_issue_i = 1; mc_issue_rd_i = 10;
    settle();
    check("rst2_we", 32'(RegWrite_o), 32'd0);
    check("rst2_stall", 32'(wb_stall_o), 32'd0);
    check("rst2_ready", 32'(mc_ready_o), 32'd0);
    check("rst2_hazard", 32'(hazard_o), 32'd0);
    check("rst2_addr", 32'(RDaddr_o), 32'd0);
    check("rst2_data", RDdata_o, 32'd0);
    check("rst2_pending", pending_o, 32'd0);
    step();
    check("rst2_hold_pending", pending_o, 32'd0);
    check("rst2_hold_we", 32'(RegWrite_o), 32'd0);
    step();
    rst_i = 0;
    idle_inputs();
    settle();
    check("post_rst_pending", pending_o, 32'd0);
    // State must be IDLE with cnt=0: WB keeps the port for a full 4 cycles before the force.
    starve_run("post_rst", 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
